pipelined_universal_shifter: RTL and testbench

PIPELINED_UNIVERSAL_SHIFTER -- requirements
Module: pipelined_universal_shifter

---
 rtl/pipelined_universal_shifter_if.sv | 14 +
 rtl/pipelined_universal_shifter.sv | 81 ++++++++
 tb/tb_pipelined_universal_shifter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_universal_shifter_if.sv
// pipelined_universal_shifter_if: operand/result handshake bundle for the pipelined shifter
interface pipelined_universal_shifter_if #(parameter int WIDTH = 16, parameter int SHW = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   Shift;
  logic [2:0]       Mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [SHW:0]     occupancy;
  modport master (output in_valid, A, Shift, Mode, out_ready, input in_ready, out_valid, out, occupancy);
  modport slave  (input in_valid, A, Shift, Mode, out_ready, output in_ready, out_valid, out, occupancy);
endinterface

// File: rtl/pipelined_universal_shifter.sv
// pipelined_universal_shifter: log-stage barrel shifter, stage k shifts by 2^k, whole pipe stalls on output backpressure
module pipelined_universal_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input logic clk,
  input logic reset,
  pipelined_universal_shifter_if.slave bus
);
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [WIDTH-1:0] src_data [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [SHW-1:0]   shamt_d [SHW];
  logic [SHW-1:0]   src_shamt [SHW];
  logic [2:0]       mode_q [SHW];
  logic [2:0]       src_mode [SHW];
  logic [SHW-1:0]   vld_q;
  logic [SHW-1:0]   src_vld;
  logic [SHW:0]     occ_q;
  logic [SHW:0]     occ_d;
  logic             adv;
  logic             acc;
  logic             ret;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [2:0] m, input int n);
    logic signed [WIDTH-1:0] asr;
    asr = $signed(d) >>> n;
    return m == 3'b000 ? d >> n :
           m == 3'b001 ? d << n :
           m == 3'b010 ? asr :
           m == 3'b011 ? (d >> n) | (d << (WIDTH - n)) :
           m == 3'b100 ? (d << n) | (d >> (WIDTH - n)) : d;
  endfunction

  // remaining shift bits travel right-aligned, so every stage consumes bit 0
  always_comb begin
    src_data[0]  = bus.A;
    src_shamt[0] = bus.Shift;
    src_mode[0]  = bus.Mode;
    src_vld[0]   = bus.in_valid;
    for (int k = 1; k < SHW; k++) begin
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_vld[k]   = vld_q[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      data_d[k]  = src_shamt[k][0] ? step(src_data[k], src_mode[k], 1 << k) : src_data[k];
      shamt_d[k] = src_shamt[k] >> 1;
    end
  end

  assign adv           = !vld_q[SHW-1] | bus.out_ready;
  assign acc           = bus.in_valid & adv;
  assign ret           = vld_q[SHW-1] & bus.out_ready;
  assign occ_d         = occ_q + (SHW+1)'(acc) - (SHW+1)'(ret);
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[SHW-1];
  assign bus.out       = data_q[SHW-1];
  assign bus.occupancy = occ_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
      end
    end else begin
      occ_q <= occ_d;
      if (adv) begin
        vld_q   <= src_vld;
        data_q  <= data_d;
        shamt_q <= shamt_d;
        mode_q  <= src_mode;
      end
    end
endmodule

// File: tb/tb_pipelined_universal_shifter.sv
// tb_pipelined_universal_shifter: random and directed stimulus checked against a result-level shift model
module tb_pipelined_universal_shifter;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int W2 = 32;
  localparam int S2 = 5;

  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  pipelined_universal_shifter_if #(.WIDTH(W), .SHW(S)) bus ();
  pipelined_universal_shifter_if #(.WIDTH(W2), .SHW(S2)) bus2 ();
  pipelined_universal_shifter #(.WIDTH(W), .SHW(S)) dut (.clk(clk), .reset(rst), .bus(bus));
  pipelined_universal_shifter #(.WIDTH(W2), .SHW(S2)) dut2 (.clk(clk), .reset(rst), .bus(bus2));

  int total = 0;
  int bad = 0;
  int occ_m;
  int occ_peak = 0;
  logic stop2 = 0;
  logic mv [S];
  logic [W-1:0] md [S];
  logic [63:0] q2 [$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [63:0] a, input int s, input logic [2:0] m, input int w);
    logic [63:0] mask;
    logic [63:0] fill;
    mask = (64'd1 << w) - 64'd1;
    fill = mask & ~(mask >> s);
    case (m)
      3'd0: return a >> s;
      3'd1: return (a << s) & mask;
      3'd2: return a[w-1] ? (a >> s) | fill : a >> s;
      3'd3: return ((a >> s) | (a << (w - s))) & mask;
      3'd4: return ((a << s) | (a >> (w - s))) & mask;
      default: return a;
    endcase
  endfunction

  // result-level model: S slots that advance together; a slot holds the final answer
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < S; k++) mv[k] = 1'b0;
    end else begin
      occ_m = 0;
      for (int k = 0; k < S; k++) occ_m += int'(mv[k]);
      chk("occupancy", 64'(bus.occupancy), 64'(occ_m));
      if (int'(bus.occupancy) > occ_peak) occ_peak = int'(bus.occupancy);
      chk("in_ready", 64'(bus.in_ready), 64'(!mv[S-1] || bus.out_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(mv[S-1]));
      if (mv[S-1]) chk("out", 64'(bus.out), 64'(md[S-1]));
      if (!mv[S-1] || bus.out_ready) begin
        for (int k = S - 1; k > 0; k--) begin
          mv[k] = mv[k-1];
          md[k] = md[k-1];
        end
        mv[0] = bus.in_valid;
        md[0] = W'(ref_shift(64'(bus.A), int'(bus.Shift), bus.Mode, W));
      end
    end
  end

  always @(negedge clk) begin
    if (rst) q2.delete();
    else begin
      chk("occupancy32", 64'(bus2.occupancy), 64'(q2.size()));
      chk("in_ready32", 64'(bus2.in_ready), 64'(!bus2.out_valid || bus2.out_ready));
      if (bus2.out_valid && bus2.out_ready) begin
        if (q2.size() == 0) chk("extra32", 64'(bus2.out_valid), 64'd0);
        else chk("out32", 64'(bus2.out), q2.pop_front());
      end
      if (bus2.in_valid && bus2.in_ready)
        q2.push_back(ref_shift(64'(bus2.A), int'(bus2.Shift), bus2.Mode, W2));
    end
  end

  initial begin
    bus2.in_valid = 0; bus2.A = '0; bus2.Shift = '0; bus2.Mode = '0; bus2.out_ready = 1;
    @(negedge rst);
    while (!stop2) begin
      @(posedge clk); #1;
      bus2.in_valid  = 1'($urandom);
      bus2.A         = W2'($urandom);
      bus2.Shift     = S2'($urandom);
      bus2.Mode      = 3'($urandom_range(0, 7));
      bus2.out_ready = ($urandom % 4) != 0;
    end
    bus2.in_valid = 0;
    bus2.out_ready = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic put(input logic v, input logic [W-1:0] a, input logic [S-1:0] s, input logic [2:0] m, input logic r);
    bus.in_valid = v; bus.A = a; bus.Shift = s; bus.Mode = m; bus.out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, '0, '0, '0, 1'b1);
  endtask

  logic [W-1:0] held;
  int lat;

  initial begin
    bus.in_valid = 0; bus.A = '0; bus.Shift = '0; bus.Mode = '0; bus.out_ready = 1;
    rst = 1;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("pin_lsr", ref_shift(64'h B252, 3, 3'd0, 16), 64'h164A);
    chk("pin_lsl", ref_shift(64'h B252, 3, 3'd1, 16), 64'h9290);
    chk("pin_asr", ref_shift(64'h B252, 3, 3'd2, 16), 64'hF64A);
    chk("pin_ror", ref_shift(64'h B252, 3, 3'd3, 16), 64'h564A);
    chk("pin_rol", ref_shift(64'h B252, 3, 3'd4, 16), 64'h9295);
    chk("pin_asr15", ref_shift(64'h8000, 15, 3'd2, 16), 64'hFFFF);
    chk("pin_rol15", ref_shift(64'h0001, 15, 3'd4, 16), 64'h8000);
    chk("pin_rsvd", ref_shift(64'h1234, 5, 3'd7, 16), 64'h1234);
    @(posedge clk); #1;
    for (int m = 0; m < 5; m++) put(1'b1, 16'hB252, 4'd3, 3'(m), 1'b1);
    idle(6);
    occ_peak = 0;
    for (int i = 0; i < 8; i++) put(1'b1, W'($urandom), S'($urandom), 3'($urandom_range(0, 4)), 1'b1);
    idle(6);
    chk("occ_peak", 64'(occ_peak), 64'd4);
    for (int m = 0; m < 8; m++) put(1'b1, W'($urandom), 4'd0, 3'(m), 1'b1);
    put(1'b1, 16'h8000, 4'd15, 3'd2, 1'b1);
    put(1'b1, 16'h0001, 4'd15, 3'd4, 1'b1);
    put(1'b1, W'($urandom), 4'd9, 3'd7, 1'b1);
    idle(6);
    for (int i = 0; i < 4; i++) put(1'b1, W'($urandom), S'($urandom), 3'($urandom_range(0, 7)), 1'b0);
    bus.in_valid = 1; bus.A = 16'hDEAD; bus.out_ready = 0;
    #1;
    held = bus.out;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out", 64'(bus.out), 64'(held));
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_occ", 64'(bus.occupancy), 64'd4);
      @(posedge clk); #2;
    end
    bus.in_valid = 0; bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("release_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;
    end
    idle(4);
    for (int i = 0; i < 3; i++) put(1'b1, W'($urandom), S'($urandom), 3'($urandom_range(0, 7)), 1'b1);
    bus.in_valid = 0;
    #1;
    rst = 1;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_occ", 64'(bus.occupancy), 64'd0);
    chk("mid_rst_out", 64'(bus.out), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      chk("no_stale", 64'(bus.out_valid), 64'd0);
      idle(1);
    end
    put(1'b1, 16'hB252, 4'd3, 3'd4, 1'b1);
    bus.in_valid = 0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    chk("latency_out", 64'(bus.out), 64'h9295);
    idle(6);
    for (int i = 0; i < 400; i++)
      put(($urandom % 4) != 0, W'($urandom), S'($urandom), 3'($urandom_range(0, 7)), ($urandom % 3) != 0);
    stop2 = 1;
    idle(12);
    chk("drain_occ16", 64'(bus.occupancy), 64'd0);
    chk("drain32", 64'(q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
